qvga_frame_fetch: RTL and testbench

- Read-side frame-buffer fetch stage. Sits directly upstream of the image filter stage.
- Turns the VGA timing stream (DE, x, y) into synchronous-BRAM read requests for a 160x120 RGB444 double-buffered frame. The frame is shown 2x upscaled in the 640x480 bottom-right quadrant.
- Delivers timing-aligned DE/x/y/RGB to the filter.
- Owns the display-bank swap handshake with the camera write side.

---
 rtl/qvga_frame_fetch.sv | 154 +++++++++++++++
 tb/tb_qvga_frame_fetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/qvga_frame_fetch.sv
// Read-side frame-buffer fetch: maps the VGA raster onto BRAM reads of a 2x upscaled,
// double-buffered 160x120 RGB444 frame. Optional FRAME_STATS_EN adds drop/swap counters.
module qvga_frame_fetch #(
   parameter int          IMG_WIDTH   = 160,
   parameter int          IMG_HEIGHT  = 120,
   parameter int          WIN_X0      = 320,
   parameter int          WIN_Y0      = 240,
   parameter int          V_ACTIVE    = 480,
   parameter int          MEM_LATENCY = 2,
   parameter int          ADDR_W      = 16,
   parameter logic [11:0] BG_COLOR    = 12'h000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              DE_in,
   input  logic [9:0]        x_in,
   input  logic [9:0]        y_in,
   input  logic              wr_frame_done,
   output logic              rd_bank,
   output logic              frame_swap,
`ifdef FRAME_STATS_EN
   output logic [15:0]       drop_cnt,
   output logic [15:0]       swap_cnt,
`endif
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [11:0]       rd_data,
   output logic              DE_out,
   output logic [9:0]        x_out,
   output logic [9:0]        y_out,
   output logic [3:0]        r_out,
   output logic [3:0]        g_out,
   output logic [3:0]        b_out
);

   localparam int          L           = 1 + MEM_LATENCY;
   localparam int          FRAME_WORDS = IMG_WIDTH * IMG_HEIGHT;
   localparam logic [9:0]  X_LO        = 10'(WIN_X0);
   localparam logic [9:0]  X_HI        = 10'(WIN_X0 + 2 * IMG_WIDTH - 1);
   localparam logic [9:0]  Y_LO        = 10'(WIN_Y0);
   localparam logic [9:0]  Y_HI        = 10'(WIN_Y0 + 2 * IMG_HEIGHT - 1);
   localparam logic [9:0]  V_LIM       = 10'(V_ACTIVE);

   typedef enum logic {SHOW, PENDING} bank_state_t;

   bank_state_t       state, state_nxt;
   logic              swap_now;
   logic              in_win, vblank, above_win, line_odd, last_px;
   logic [ADDR_W-1:0] local_x, bank_base, row_base;
   logic [L-1:0]      de_pipe, win_pipe;
   logic [9:0]        x_pipe [L];
   logic [9:0]        y_pipe [L];

   always_comb begin
      vblank    = (y_in >= V_LIM);
      above_win = (y_in < Y_LO);
      in_win    = DE_in && (x_in >= X_LO) && (x_in <= X_HI) && (y_in >= Y_LO) && (y_in <= Y_HI);
      line_odd  = y_in[0] ^ Y_LO[0];
      last_px   = in_win && (x_in == X_HI);
      local_x   = ADDR_W'((x_in - X_LO) >> 1);
      bank_base = rd_bank ? ADDR_W'(FRAME_WORDS) : '0;
   end

   // Each source line is fetched for two display lines; the base advances after the second.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_base <= '0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
      end else begin
         if (above_win || vblank)
            row_base <= '0;
         else if (last_px && line_odd)
            row_base <= row_base + ADDR_W'(IMG_WIDTH);
         rd_en   <= in_win;
         rd_addr <= bank_base + row_base + local_x;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         de_pipe  <= '0;
         win_pipe <= '0;
         for (int i = 0; i < L; i++) begin
            x_pipe[i] <= '0;
            y_pipe[i] <= '0;
         end
      end else begin
         de_pipe  <= {de_pipe[L-2:0], DE_in};
         win_pipe <= {win_pipe[L-2:0], in_win};
         x_pipe[0] <= x_in;
         y_pipe[0] <= y_in;
         for (int i = 1; i < L; i++) begin
            x_pipe[i] <= x_pipe[i-1];
            y_pipe[i] <= y_pipe[i-1];
         end
      end
   end

   // rd_data is already the BRAM's output register, so the colour select needs no extra stage.
   always_comb begin
      DE_out                 = de_pipe[L-1];
      x_out                  = x_pipe[L-1];
      y_out                  = y_pipe[L-1];
      {r_out, g_out, b_out}  = win_pipe[L-1] ? rd_data : BG_COLOR;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= SHOW;
         rd_bank    <= 1'b0;
         frame_swap <= 1'b0;
      end else begin
         state      <= state_nxt;
         rd_bank    <= rd_bank ^ swap_now;
         frame_swap <= swap_now;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SHOW:    if (wr_frame_done) state_nxt = PENDING;
         PENDING: if (vblank)        state_nxt = SHOW;
         default:                    state_nxt = SHOW;
      endcase
   end

   // Bank only flips in vertical blank so a displayed frame is never torn.
   always_comb begin
      swap_now = (state == PENDING) && vblank;
   end

`ifdef FRAME_STATS_EN
   logic absorb;

   always_comb begin
      absorb = (state == PENDING) && wr_frame_done;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_cnt <= '0;
         swap_cnt <= '0;
      end else begin
         if (absorb && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
         if (swap_now && (swap_cnt != 16'hFFFF))
            swap_cnt <= swap_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_qvga_frame_fetch.sv
// Directed bench for qvga_frame_fetch with a 2-cycle BRAM model; checks stats when FRAME_STATS_EN is set.
module tb_qvga_frame_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        DE_in;
   logic [9:0]  x_in, y_in;
   logic        wr_frame_done;
   logic        rd_bank, frame_swap, rd_en;
   logic [15:0] rd_addr;
   logic [11:0] rd_data;
   logic        DE_out;
   logic [9:0]  x_out, y_out;
   logic [3:0]  r_out, g_out, b_out;
`ifdef FRAME_STATS_EN
   logic [15:0] drop_cnt, swap_cnt;
`endif

   int compared = 0;
   int mismatched = 0;

   logic [11:0] p1, p2;

   always #5 clk = ~clk;

   qvga_frame_fetch #(.MEM_LATENCY(2)) dut (
      .clk(clk), .reset(reset), .DE_in(DE_in), .x_in(x_in), .y_in(y_in),
      .wr_frame_done(wr_frame_done), .rd_bank(rd_bank), .frame_swap(frame_swap),
`ifdef FRAME_STATS_EN
      .drop_cnt(drop_cnt), .swap_cnt(swap_cnt),
`endif
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .DE_out(DE_out),
      .x_out(x_out), .y_out(y_out), .r_out(r_out), .g_out(g_out), .b_out(b_out)
   );

   function automatic logic [11:0] mem_word(input int a);
      return 12'(a * 7 + 3);
   endfunction

   // Two-stage synchronous BRAM: data valid two cycles after rd_en.
   always @(posedge clk) begin
      if (rd_en) p1 <= mem_word(int'(rd_addr));
      p2 <= p1;
   end
   assign rd_data = p2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic de, input int x, input int y, input logic wfd);
      DE_in = de;
      x_in = 10'(x);
      y_in = 10'(y);
      wr_frame_done = wfd;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rgb();
      return {20'd0, r_out, g_out, b_out};
   endfunction

   initial begin
      reset = 1'b0; DE_in = 1'b0; x_in = '0; y_in = '0; wr_frame_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_de_out", DE_out, 0);
      check("rst_x_out", x_out, 0);
      check("rst_rd_bank", rd_bank, 0);
      check("rst_swap", frame_swap, 0);
      check("rst_rgb", rgb(), 0);
      reset = 1'b1;

      cyc(1, 320, 240, 0); check("win_rd_en", rd_en, 1); check("addr_320", rd_addr, 0);
      cyc(1, 321, 240, 0); check("addr_321", rd_addr, 0);
      cyc(1, 322, 240, 0);
      check("addr_322", rd_addr, 1);
      check("lat_de", DE_out, 1); check("lat_x", x_out, 320); check("lat_y", y_out, 240);
      check("lat_rgb", rgb(), {20'd0, mem_word(0)});
      cyc(1, 323, 240, 0); check("addr_323", rd_addr, 1); check("x_321", x_out, 321);
      cyc(0, 320, 240, 0); check("de0_rd_en", rd_en, 0); check("rgb_322", rgb(), {20'd0, mem_word(1)});
      cyc(1, 100, 100, 0); check("out_rd_en_a", rd_en, 0);
      cyc(1, 330, 200, 0); check("out_rd_en_b", rd_en, 0); check("de0_out", DE_out, 0);
      cyc(0, 0, 0, 0);
      check("bg_de_a", DE_out, 1); check("bg_x_a", x_out, 100); check("bg_rgb_a", rgb(), 0);
      cyc(0, 0, 0, 0);
      check("bg_x_b", x_out, 330); check("bg_y_b", y_out, 200); check("bg_rgb_b", rgb(), 0);

      cyc(1, 320, 241, 0); check("addr_241", rd_addr, 0);
      cyc(1, 639, 241, 0); check("addr_639_241", rd_addr, 159);
      cyc(1, 320, 242, 0); check("addr_242", rd_addr, 160);
      for (int y = 243; y <= 477; y += 2) cyc(1, 639, y, 0);
      cyc(1, 639, 479, 0); check("addr_last", rd_addr, 19199);

      cyc(1, 400, 300, 1); check("pend_bank_a", rd_bank, 0); check("pend_swap_a", frame_swap, 0);
      cyc(1, 401, 300, 0); check("pend_bank_b", rd_bank, 0);
      cyc(0, 0, 479, 0); check("pend_bank_c", rd_bank, 0); check("pend_swap_c", frame_swap, 0);
      cyc(0, 0, 480, 0); check("swap_bank", rd_bank, 1); check("swap_pulse", frame_swap, 1);
      cyc(0, 0, 481, 0); check("swap_end", frame_swap, 0); check("swap_hold", rd_bank, 1);
      cyc(1, 320, 240, 0); check("bank1_addr", rd_addr, 19200);
      cyc(1, 322, 240, 0); check("bank1_addr2", rd_addr, 19201);
      cyc(0, 0, 250, 0); check("bank1_rgb", rgb(), {20'd0, mem_word(19200)});

      cyc(0, 0, 490, 1); check("vb_bank_a", rd_bank, 1); check("vb_swap_a", frame_swap, 0);
      cyc(0, 0, 491, 0); check("vb_bank_b", rd_bank, 0); check("vb_swap_b", frame_swap, 1);
      cyc(0, 0, 492, 0); check("vb_swap_c", frame_swap, 0);

      cyc(1, 320, 250, 1);
      cyc(1, 322, 250, 1);
      cyc(0, 0, 300, 1); check("multi_bank_a", rd_bank, 0); check("multi_swap_a", frame_swap, 0);
      cyc(0, 0, 480, 0); check("multi_bank_b", rd_bank, 1); check("multi_swap_b", frame_swap, 1);
      cyc(0, 0, 481, 0); check("multi_swap_c", frame_swap, 0);
`ifdef FRAME_STATS_EN
      check("drop_cnt", drop_cnt, 2);
      check("swap_cnt", swap_cnt, 3);
`endif

      cyc(0, 0, 0, 0);
      cyc(1, 400, 300, 0);
      cyc(1, 402, 300, 0);
      cyc(1, 404, 300, 0);
      check("pre_rst_de", DE_out, 1); check("pre_rst_rd_en", rd_en, 1); check("pre_rst_bank", rd_bank, 1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_bank", rd_bank, 0);
      check("mid_rst_rd_en", rd_en, 0);
      check("mid_rst_addr", rd_addr, 0);
      check("mid_rst_de", DE_out, 0);
      check("mid_rst_x", x_out, 0);
      check("mid_rst_y", y_out, 0);
      check("mid_rst_rgb", rgb(), 0);
`ifdef FRAME_STATS_EN
      check("mid_rst_drop", drop_cnt, 0);
      check("mid_rst_swaps", swap_cnt, 0);
`endif
      @(negedge clk);
      reset = 1'b1;
      cyc(0, 0, 500, 0);
      cyc(1, 320, 240, 0); check("post_rst_en", rd_en, 1); check("post_rst_addr", rd_addr, 0);
      cyc(1, 322, 240, 0); check("post_rst_addr2", rd_addr, 1);
      cyc(0, 0, 250, 0);
      check("post_rst_x", x_out, 320); check("post_rst_rgb", rgb(), {20'd0, mem_word(0)});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
